// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cpu_run_ctrl
// Brief    : Run/halt/single-step sequencer with PC breakpoint, halt-on-syscall
//            and instret/cycle performance counters for the single-cycle CPU.
// Revision : 1.0
// ============================================================================
module cpu_run_ctrl #(
    parameter int STEPW        = 16,
    parameter bit SYSCALL_HALT = 1'b1
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             run_req,
    input  logic             halt_req,
    input  logic             step_req,
    input  logic [STEPW-1:0] step_count,
    input  logic             bp_en,
    input  logic [31:0]      bp_addr,
    input  logic [31:0]      pc,
    input  logic [31:0]      inst,
    output logic             cpu_en,
    output logic [1:0]       state,
    output logic [1:0]       halt_cause,
    output logic [31:0]      instret,
    output logic [31:0]      cycle_cnt
);

    typedef enum logic [1:0] {
        ST_HALT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_STEP  = 2'b10,
        ST_BREAK = 2'b11
    } state_t;

    localparam logic [1:0] C_CAUSE_HOST    = 2'b00;
    localparam logic [1:0] C_CAUSE_STEP    = 2'b01;
    localparam logic [1:0] C_CAUSE_BP      = 2'b10;
    localparam logic [1:0] C_CAUSE_SC      = 2'b11;
    localparam logic [5:0] C_FUNCT_SYSCALL = 6'b001100;

    state_t             state_q, state_d;
    logic [1:0]         halt_cause_q, halt_cause_d;
    logic [STEPW-1:0]   step_left_q, step_left_d;
    logic               bp_skip_q, bp_skip_d;
    logic [31:0]        instret_q, instret_d;
    logic [31:0]        cycle_cnt_q, cycle_cnt_d;

    logic               w_active;
    logic               w_pc_hit;
    logic               w_bp;
    logic               w_sc;
    logic               w_cpu_en;

    always_comb begin
        w_active = (state_q == ST_RUN) || (state_q == ST_STEP);
        w_pc_hit = (pc == bp_addr);
        w_bp     = bp_en && w_pc_hit && !bp_skip_q;
        w_sc     = SYSCALL_HALT && (inst[31:26] == 6'd0) && (inst[5:0] == C_FUNCT_SYSCALL);
        // Held low during reset so nothing retires while the sequencer is initialising.
        w_cpu_en = resetn && w_active && !halt_req && !w_bp && !w_sc;
    end

    always_comb begin
        state_d      = state_q;
        halt_cause_d = halt_cause_q;
        step_left_d  = step_left_q;
        bp_skip_d    = bp_skip_q;

        if (w_active) begin
            if (halt_req) begin
                state_d      = ST_HALT;
                halt_cause_d = C_CAUSE_HOST;
            end else if (w_bp) begin
                state_d      = ST_BREAK;
                halt_cause_d = C_CAUSE_BP;
            end else if (w_sc) begin
                state_d      = ST_HALT;
                halt_cause_d = C_CAUSE_SC;
            end else if (state_q == ST_STEP) begin
                step_left_d = step_left_q - STEPW'(1);
                if (step_left_q == STEPW'(1)) begin
                    state_d      = ST_HALT;
                    halt_cause_d = C_CAUSE_STEP;
                end
            end
        end else if (!halt_req) begin
            if (run_req) begin
                state_d = ST_RUN;
            end else if (step_req && (step_count != '0)) begin
                state_d     = ST_STEP;
                step_left_d = step_count;
            end
        end

        // Skip flag lets the instruction sitting on the breakpoint retire once on resume.
        if (w_cpu_en) begin
            bp_skip_d = 1'b0;
        end
        if (w_active && ((state_d == ST_HALT) || (state_d == ST_BREAK))) begin
            bp_skip_d = 1'b0;
        end
        if ((state_q == ST_BREAK) && (state_d != ST_BREAK)) begin
            bp_skip_d = 1'b1;
        end
        if ((state_q == ST_HALT) && (state_d != ST_HALT) && w_pc_hit) begin
            bp_skip_d = 1'b1;
        end

        instret_d   = instret_q + {31'd0, w_cpu_en};
        cycle_cnt_d = cycle_cnt_q + 32'd1;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q      <= ST_HALT;
            halt_cause_q <= C_CAUSE_HOST;
            step_left_q  <= '0;
            bp_skip_q    <= 1'b0;
            instret_q    <= 32'd0;
            cycle_cnt_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            halt_cause_q <= halt_cause_d;
            step_left_q  <= step_left_d;
            bp_skip_q    <= bp_skip_d;
            instret_q    <= instret_d;
            cycle_cnt_q  <= cycle_cnt_d;
        end
    end

    assign cpu_en     = w_cpu_en;
    assign state      = state_q;
    assign halt_cause = halt_cause_q;
    assign instret    = instret_q;
    assign cycle_cnt  = cycle_cnt_q;

endmodule
`default_nettype wire
